// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Handshake/data bundle between the Execute stage (master) and the
//   iterative multiply/divide unit (slave).
//   master -> slave : StartE, OpE, SrcAE, SrcBE, FlushE
//   slave -> master : BusyE, DoneE, ResultLoE, ResultHiE, DivByZeroE
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             FlushE;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] ResultLoE;
  logic [WIDTH-1:0] ResultHiE;
  logic             DivByZeroE;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, FlushE,
    input  BusyE, DoneE, ResultLoE, ResultHiE, DivByZeroE
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, FlushE,
    output BusyE, DoneE, ResultLoE, ResultHiE, DivByZeroE
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit for the Execute stage. Accepts one
//   MUL / UMULL / UDIV / SDIV, runs a shift-add multiply or a restoring
//   divide one bit per cycle, and requests a pipeline stall (BusyE) until
//   the result is presented for one cycle with DoneE.
//
//   Ports:
//     clk    rising-edge core clock
//     reset  asynchronous, active-low; forces IDLE and clears all registers
//     bus    muldiv_sequencer_if.slave (StartE/OpE/SrcAE/SrcBE/FlushE in,
//            BusyE/DoneE/ResultLoE/ResultHiE/DivByZeroE out)
//
//   Build option:
//     MULDIV_SDIV_EN  when defined, OpE=11 is a signed divide (magnitude
//                     divide followed by a FIX sign-correction cycle);
//                     when undefined, OpE=11 is identical to UDIV.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   opnd_reg;        // multiplicand, or divisor magnitude
  logic [2*WIDTH-1:0] acc_reg;         // {high/remainder, low/quotient}
  logic [WIDTH-1:0]   res_lo_reg, res_hi_reg;
  logic               dbz_reg;

  // FSM output-process signals
  logic               busy;
  logic               done;
  logic               res_load;
  logic [WIDTH-1:0]   res_lo_next, res_hi_next;
  logic               dbz_next;

  logic               accept;
  logic               divisor_zero;
  logic               last_step;
  logic               div_to_fix;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign accept       = (state_reg == S_IDLE) && bus.StartE && !bus.FlushE;
  assign divisor_zero = (bus.SrcBE == '0);
  assign last_step    = (count_reg == CW'(1));

`ifdef MULDIV_SDIV_EN
  logic             sdiv_in;
  logic             sdiv_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] fix_lo, fix_hi;

  assign sdiv_in    = (bus.OpE == 2'b11);
  // Signed divide runs the unsigned datapath on magnitudes. The most
  // negative value maps to itself, which is its correct unsigned magnitude.
  assign a_mag      = (sdiv_in && bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
  assign b_mag      = (sdiv_in && bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
  assign div_to_fix = sdiv_reg;
  assign fix_lo     = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign fix_hi     = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
`else
  assign a_mag      = bus.SrcAE;
  assign b_mag      = bus.SrcBE;
  assign div_to_fix = 1'b0;
`endif

  // Shift-add multiply step: add the multiplicand into the high half when
  // the current multiplier bit (acc LSB) is set, then shift right by one.
  // The carry out of the add becomes the new top bit.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder, trial-subtract the divisor, keep the difference when it is
  // non-negative. The shifted remainder needs one extra bit.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  assign rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_reg};
  assign div_next = div_diff[WIDTH]
                  ? {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (!bus.OpE[1])       state_next = S_MUL;
          else if (divisor_zero) state_next = S_DONE;
          else                   state_next = S_DIV;
        end
      end
      S_MUL: begin
        if (bus.FlushE)     state_next = S_IDLE;
        else if (last_step) state_next = S_DONE;
      end
      S_DIV: begin
        if (bus.FlushE)     state_next = S_IDLE;
        else if (last_step) state_next = div_to_fix ? S_FIX : S_DONE;
      end
`ifdef MULDIV_SDIV_EN
      S_FIX: begin
        state_next = bus.FlushE ? S_IDLE : S_DONE;
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: output logic ----------------
  // Result registers are loaded only on the edge that enters DONE, so a
  // flushed or reset operation leaves the previous result untouched.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    res_load    = 1'b0;
    res_lo_next = res_lo_reg;
    res_hi_next = res_hi_reg;
    dbz_next    = dbz_reg;
    case (state_reg)
      S_IDLE: begin
        busy = accept;
        if (accept && bus.OpE[1] && divisor_zero) begin
          res_load    = 1'b1;
          res_lo_next = '0;
          res_hi_next = bus.SrcAE;
          dbz_next    = 1'b1;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (last_step && !bus.FlushE) begin
          res_load    = 1'b1;
          res_lo_next = mul_next[WIDTH-1:0];
          res_hi_next = mul_next[2*WIDTH-1:WIDTH];
          dbz_next    = 1'b0;
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_step && !bus.FlushE && !div_to_fix) begin
          res_load    = 1'b1;
          res_lo_next = div_next[WIDTH-1:0];
          res_hi_next = div_next[2*WIDTH-1:WIDTH];
          dbz_next    = 1'b0;
        end
      end
`ifdef MULDIV_SDIV_EN
      S_FIX: begin
        busy = 1'b1;
        if (!bus.FlushE) begin
          res_load    = 1'b1;
          res_lo_next = fix_lo;
          res_hi_next = fix_hi;
          dbz_next    = 1'b0;
        end
      end
`endif
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg  <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      res_lo_reg <= '0;
      res_hi_reg <= '0;
      dbz_reg    <= 1'b0;
`ifdef MULDIV_SDIV_EN
      sdiv_reg   <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        count_reg <= CW'(WIDTH);
        if (bus.OpE[1]) begin
          acc_reg  <= {{WIDTH{1'b0}}, a_mag};
          opnd_reg <= b_mag;
        end else begin
          // Multiplier sits in the low half and is consumed LSB first.
          acc_reg  <= {{WIDTH{1'b0}}, bus.SrcBE};
          opnd_reg <= bus.SrcAE;
        end
`ifdef MULDIV_SDIV_EN
        sdiv_reg  <= sdiv_in;
        neg_q_reg <= sdiv_in && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
        neg_r_reg <= sdiv_in && bus.SrcAE[WIDTH-1];
`endif
      end else if (state_reg == S_MUL) begin
        acc_reg   <= mul_next;
        count_reg <= count_reg - CW'(1);
      end else if (state_reg == S_DIV) begin
        acc_reg   <= div_next;
        count_reg <= count_reg - CW'(1);
      end

      if (res_load) begin
        res_lo_reg <= res_lo_next;
        res_hi_reg <= res_hi_next;
        dbz_reg    <= dbz_next;
      end
    end
  end

  assign bus.BusyE      = busy;
  assign bus.DoneE      = done;
  assign bus.ResultLoE  = res_lo_reg;
  assign bus.ResultHiE  = res_hi_reg;
  assign bus.DivByZeroE = dbz_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Randomized bench for muldiv_sequencer (WIDTH=32). A behavioural model
//   computes each result with plain 64-bit arithmetic and derives the cycle
//   of DoneE from the operation type; a negedge compare process checks all
//   outputs every cycle. Directed cases pin the model with literal values.
//   Honours MULDIV_SDIV_EN the same way as the design.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MULDIV_SDIV_EN
  localparam bit SDIV_EN = 1'b1;
`else
  localparam bit SDIV_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic        chk_en   = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_lo   = '0;
  logic [31:0] exp_hi   = '0;
  logic        exp_dbz  = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, want);
    end
  endtask

  // One compare process: every cycle, mid-cycle, all outputs vs model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("BusyE",      {31'b0, bus.BusyE},      {31'b0, exp_busy});
      check("DoneE",      {31'b0, bus.DoneE},      {31'b0, exp_done});
      check("ResultLoE",  bus.ResultLoE,           exp_lo);
      check("ResultHiE",  bus.ResultHiE,           exp_hi);
      check("DivByZeroE", {31'b0, bus.DivByZeroE}, {31'b0, exp_dbz});
    end
  end

  // Behavioural model: result and DoneE cycle (relative to issue) per op.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic dbz, output int lat);
    logic [63:0] p;
    longint sa, sb, q, r;
    dbz = 1'b0;
    lat = 33;
    if (!op[1]) begin
      p  = {32'b0, a} * {32'b0, b};
      lo = p[31:0];
      hi = p[63:32];
    end else if (b == 32'd0) begin
      lo  = '0;
      hi  = a;
      dbz = 1'b1;
      lat = 1;
    end else if (op == 2'b11 && SDIV_EN) begin
      sa  = $signed(a);
      sb  = $signed(b);
      q   = sa / sb;
      r   = sa % sb;
      lo  = q[31:0];
      hi  = r[31:0];
      lat = 34;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Drive one cycle's inputs just after the rising edge, set this cycle's
  // expectations, and return after the mid-cycle compare.
  task automatic step(input logic st, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic rs,
                      input logic eb, input logic ed);
    @(posedge clk);
    #1;
    reset      = rs;
    bus.StartE = st;
    bus.OpE    = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.FlushE = fl;
    exp_busy   = eb;
    exp_done   = ed;
    chk_en     = 1'b1;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at T0 and run it to DONE, or abort it at cycle abort_at
  // with FlushE (abort_rst=0) or reset (abort_rst=1). Other inputs carry
  // random junk while the unit is busy or presenting its result.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int abort_at, input logic abort_rst);
    logic [31:0] mlo, mhi;
    logic        mdbz;
    int          lat;
    model(op, a, b, mlo, mhi, mdbz, lat);
    step(1'b1, op, a, b, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= lat; t++) begin
      if (t == abort_at && t < lat) begin
        if (abort_rst) begin
          exp_lo  = '0;
          exp_hi  = '0;
          exp_dbz = 1'b0;
          step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
          step(1'($urandom), 2'($urandom), $urandom, $urandom, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        return;
      end
      if (t == lat) begin
        exp_lo  = mlo;
        exp_hi  = mhi;
        exp_dbz = mdbz;
      end
      step(1'($urandom), 2'($urandom), $urandom, $urandom, 1'b0, 1'b1, t < lat, t == lat);
    end
  endtask

  initial begin
    bus.StartE = 1'b0;
    bus.OpE    = 2'b00;
    bus.SrcAE  = '0;
    bus.SrcBE  = '0;
    bus.FlushE = 1'b0;

    // Reset state, including StartE present while in reset.
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    // StartE with FlushE in IDLE: no start.
    step(1'b1, 2'b00, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Directed cases with literal expectations.
    do_op(2'b00, 32'd7, 32'd6, -1, 1'b0);
    check("mul_7x6_lo", bus.ResultLoE, 32'd42);
    check("mul_7x6_hi", bus.ResultHiE, 32'd0);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("umull_hi", bus.ResultHiE, 32'hFFFF_FFFE);
    check("umull_lo", bus.ResultLoE, 32'h0000_0001);

    do_op(2'b10, 32'd100, 32'd7, -1, 1'b0);
    check("udiv_q", bus.ResultLoE, 32'd14);
    check("udiv_r", bus.ResultHiE, 32'd2);
    check("udiv_dbz", {31'b0, bus.DivByZeroE}, 32'd0);

    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    if (SDIV_EN) begin
      check("sdiv_q", bus.ResultLoE, 32'hFFFF_FFFD);
      check("sdiv_r", bus.ResultHiE, 32'hFFFF_FFFF);
    end else begin
      check("sdiv_as_udiv_q", bus.ResultLoE, 32'h7FFF_FFFC);
      check("sdiv_as_udiv_r", bus.ResultHiE, 32'h0000_0001);
    end

    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    if (SDIV_EN) begin
      check("sdiv_ovf_q", bus.ResultLoE, 32'h8000_0000);
      check("sdiv_ovf_r", bus.ResultHiE, 32'h0);
    end

    do_op(2'b10, 32'd5, 32'd0, -1, 1'b0);
    check("div0_lo", bus.ResultLoE, 32'd0);
    check("div0_hi", bus.ResultHiE, 32'd5);
    check("div0_flag", {31'b0, bus.DivByZeroE}, 32'd1);

    // Flush at T10, then MUL 3x3 issued at T11.
    do_op(2'b10, 32'd1000, 32'd3, 10, 1'b0);
    do_op(2'b00, 32'd3, 32'd3, -1, 1'b0);
    check("mul_after_flush", bus.ResultLoE, 32'd9);

    // Reset at T10, then MUL 3x3.
    do_op(2'b10, 32'd1000, 32'd3, 10, 1'b1);
    check("reset_abort_lo", bus.ResultLoE, 32'd0);
    do_op(2'b00, 32'd3, 32'd3, -1, 1'b0);
    check("mul_after_reset", bus.ResultLoE, 32'd9);

    // Randomized ops, back-to-back or separated by idle gaps.
    for (int n = 0; n < 40; n++) begin
      int gap;
      int ab;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 0)
          step(1'b1, 2'($urandom), $urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
        else
          step(1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 33) : -1;
      do_op(2'($urandom), rand_val(), rand_val(), ab, ($urandom_range(0, 3) == 0));
    end

    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit with its own sequencing FSM, sitting in the Execute stage beside the ALU of the pipelined ARM core. It accepts one MUL/UMULL/UDIV/SDIV operation from the E stage, runs a shift-add multiply or restoring divide over WIDTH cycles, and holds a stall request to the hazard logic until the result is ready. The hazard unit ORs BusyE into StallF/StallD/StallE; the result is muxed into ALUResultE when DoneE is high.

## Interface
- WIDTH, 32, operand width; even, ≥4
- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-low; when low, forces IDLE and clears all registers
- StartE  in  1  valid MUL/DIV instruction present in E stage
- OpE  in  2  00 MUL (low half), 01 UMULL (64-bit), 10 UDIV, 11 SDIV
- SrcAE  in  WIDTH  multiplicand / dividend
- SrcBE  in  WIDTH  multiplier / divisor
- FlushE  in  1  cancel the E-stage instruction (branch mispredict)
- BusyE  out  1  stall request to hazard unit
- DoneE  out  1  result valid this cycle; instruction may advance to M
- ResultLoE  out  WIDTH  product low / quotient
- ResultHiE  out  WIDTH  product high / remainder
- DivByZeroE  out  1  divisor was zero (valid with DoneE)

## Operation
- States: IDLE, MUL, DIV, FIX, DONE; iteration counter of clog2(WIDTH)+1 bits.
- IDLE: if StartE & ~FlushE, latch operands and op. Then go to MUL (OpE 0x), DIV (OpE 1x, SrcBE≠0) or DONE (OpE 1x, SrcBE=0); load counter = WIDTH.
- MUL: one shift-add step per cycle into a 2·WIDTH accumulator; counter decrements; at counter=1 → DONE.
- DIV: one restoring step per cycle. UDIV operates on raw operands. SDIV operates on magnitudes, recording sign of quotient (signA^signB) and remainder (signA). At counter=1 → FIX for SDIV, else DONE.
- FIX: negate quotient/remainder per recorded signs; → DONE.
- DONE: DoneE=1, outputs valid; StartE ignored (same instruction still in E); → IDLE.
- Divide by zero: ResultLoE=0, ResultHiE=dividend, DivByZeroE=1.
- MUL writes only ResultLoE; ResultHiE also holds the high half, but the pipeline ignores it.
- SDIV overflow (−2^(WIDTH−1) / −1): quotient 0x80000000, remainder 0; no flag.
- FlushE in any non-IDLE state → IDLE on next edge; no DoneE; results unchanged.
- FlushE concurrent with StartE in IDLE: no start.
- Reset mid-operation aborts immediately; no DoneE.

## Timing
- BusyE = (IDLE & StartE & ~FlushE) | MUL | DIV | FIX. It is combinational from StartE, so the stall applies in the issue cycle.
- Issue cycle T0 (IDLE). MUL/UMULL/UDIV: T1..T32 iterate, DONE at T33, BusyE high T0..T32 (33 cycles). SDIV: FIX at T33, DONE at T34.
- Divide by zero: DONE at T1; BusyE high only T0.
- DoneE is high exactly one cycle. BusyE is low in DONE.
- ResultLoE/ResultHiE/DivByZeroE are registered. They hold until the next DONE.
- Reset values: state IDLE, BusyE=0, DoneE=0, ResultLoE=0, ResultHiE=0, DivByZeroE=0, counter 0.
- Back-to-back: the next StartE is accepted in the IDLE cycle immediately after DONE.

## Configuration
- MULDIV_SDIV_EN defined: OpE=11 performs signed division, including sign capture and the FIX state.
- MULDIV_SDIV_EN undefined: FIX state and sign logic are removed; OpE=11 behaves exactly as UDIV (DONE at T33).

## Test plan
- MUL 7×6 at T0 → BusyE high T0..T32, DoneE at T33, ResultLoE=42, ResultHiE=0.
- UMULL 0xFFFFFFFF×0xFFFFFFFF → at DONE, ResultHiE=0xFFFFFFFE, ResultLoE=0x00000001.
- UDIV 100/7 → DoneE at T33, ResultLoE=14, ResultHiE=2, DivByZeroE=0.
- SDIV −7/2 with MULDIV_SDIV_EN → DoneE at T34, ResultLoE=0xFFFFFFFD, ResultHiE=0xFFFFFFFF. Without the macro, the same op gives UDIV of 0xFFFFFFF9/2 at T33.
- UDIV 5/0 → DoneE at T1, ResultLoE=0, ResultHiE=5, DivByZeroE=1, BusyE high only T0.
- UDIV started T0, FlushE at T10 → IDLE at T11, no DoneE, BusyE low T11; new MUL 3×3 at T11 → DoneE at T44, ResultLoE=9. Repeat with reset low at T10 → all outputs 0 immediately.
